data_ram_lsu: RTL and testbench
===============================

DATA_RAM_LSU -- requirements
Module: data_ram_lsu

Interface
REQ-001 Parameter AW, default 32, request byte-address width.
REQ-002 Parameter DEPTH, default 1024, memory depth in 32-bit words; power of two, minimum 4.
REQ-003 Parameter WAIT_STATES, default 0, extra access cycles, range 0..15.
REQ-004 Port clk  in  1  the single clock; all logic on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port req_valid  in  1  request present.
REQ-007 Port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 Port req_we  in  1  1 = store, 0 = load.
REQ-009 Port req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 Port req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); otherwise sign-extends.
REQ-011 Port req_addr  in  AW  byte address.
REQ-012 Port req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 Port rsp_valid  out  1  one-cycle response pulse.
REQ-014 Port rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 Port rsp_err  out  1  access fault; valid only with rsp_valid.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on accept, capture all request fields; go to WAIT if WAIT_STATES > 0, else RESP.
REQ-018 WAIT: count down WAIT_STATES cycles, then go to RESP; requests are not accepted.
REQ-019 RESP: perform the RAM access in that cycle, drive rsp_valid = 1 the following cycle, and return to IDLE.
REQ-020 Load latency: rsp_valid rises exactly 2 + WAIT_STATES cycles after the accept edge.
REQ-021 Store latency is identical; the write is committed on the RESP edge; a store acknowledge carries rsp_rdata = 0.
REQ-022 Word index is addr[clog2(DEPTH)+1:2]; the byte lane is addr[1:0].
REQ-023 Store byte enables: byte writes lane addr[1:0], half writes lanes {addr[1],0}+0/1, and word writes all four lanes; other lanes are unchanged.
REQ-024 Load extraction uses the same lane selection, shifted to bit 0 and extended per req_unsigned; a word load ignores req_unsigned.
REQ-025 An address >= DEPTH*4, or req_size == 3, SHALL give rsp_err = 1, rsp_rdata = 0, and no write.
REQ-026 A faulted request SHALL still take the full latency of REQ-020.
REQ-027 When rsp_valid = 0, rsp_rdata and rsp_err SHALL be 0.
REQ-028 req_valid asserted outside IDLE is ignored; the requester holds it until accepted.

Reset
REQ-029 Reset SHALL set the FSM to IDLE, the wait counter to 0, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0; req_ready = 1 in the cycle after reset.
REQ-030 Reset in WAIT or RESP SHALL cancel the pending access; no write commits and no response issues.
REQ-031 Memory contents are not affected by reset.

Configuration
REQ-032 Macro DMEM_MISALIGN_CHK_EN: when defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL give rsp_err = 1 and no write.
REQ-033 Without DMEM_MISALIGN_CHK_EN, the misaligned low address bits are forced to 0 (half: addr[0]; word: addr[1:0]) and the access proceeds with no error.

Structure
REQ-034 Shared package dmem_pkg holds the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state typedef.
REQ-035 One sub-module, dmem_byte_ram: DEPTH x 4 byte-lane RAM with a 4-bit write enable and a synchronous read.

Verification
REQ-036 WAIT_STATES = 0: SW 0x8765_4321 to 0x10, then LW 0x10 -> rsp_rdata = 0x8765_4321, rsp_valid 2 cycles after accept.
REQ-037 After REQ-036: LB 0x13 -> 0xFFFF_FF87; LBU 0x13 -> 0x0000_0087; LH 0x10 -> 0x0000_4321; LHU 0x12 -> 0x0000_8765.
REQ-038 SB 0xAA to 0x11, then LW 0x10 -> 0x8765_AA21 (other lanes unchanged).
REQ-039 With DMEM_MISALIGN_CHK_EN defined, SW to 0x22 -> rsp_err = 1, and a following LW 0x20 returns the prior value; a load from DEPTH*4 -> rsp_err = 1, rsp_rdata = 0.
REQ-040 WAIT_STATES = 3: SW to 0x40 with rst_n low on the second WAIT cycle -> no rsp_valid, and LW 0x40 returns the old data 5 cycles after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-RAM load/store unit: access sizes, FSM states,
// and the byte-lane write-mask helper.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Lanes touched by an access; lane is already aligned to the access size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << lane;
      SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH x 32-bit RAM built from four independent byte lanes, each with its own
// write enable and a registered (read-before-write) output.
module dmem_byte_ram #(
  parameter int DEPTH = 1024,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            mem[addr] <= wdata[8*gi +: 8];
          end
          q <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = q;
    end
  endgenerate

endmodule

// File: rtl/data_ram_lsu.sv
// Load/store unit in front of a byte-lane data RAM: IDLE -> (WAIT) -> RESP FSM.
// Optional build macro DMEM_MISALIGN_CHK_EN turns misaligned half/word accesses into faults.
module data_ram_lsu
  import dmem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IW = $clog2(DEPTH);

  state_t        state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          accept;
  logic          out_of_range;
  logic          fault;
  logic [1:0]    lane;

  logic          we_q, uns_q, err_q, rsp_valid_q;
  logic [1:0]    size_q, lane_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata, ram_rdata, shifted, load_data;

  // Any address bit above the RAM's byte range means the access is out of range.
  generate
    if (AW > IW + 2) begin : g_range
      assign out_of_range = |req_addr[AW-1:IW+2];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    case (req_size)
      SZ_H:    lane = {req_addr[1], 1'b0};
      SZ_W:    lane = 2'b00;
      default: lane = req_addr[1:0];
    endcase
  end

  // A forced-down lane differs from the raw low bits exactly when misaligned.
`ifdef DMEM_MISALIGN_CHK_EN
  assign fault = (req_size == SZ_RSV) || out_of_range || (lane != req_addr[1:0]);
`else
  assign fault = (req_size == SZ_RSV) || out_of_range;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    req_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      rsp_valid_q <= (state == ST_RESP);
    end
  end

  // Captured fields stay stable through the response cycle: the next accept
  // can only land on the edge that ends it.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      lane_q  <= lane;
      idx_q   <= req_addr[IW+1:2];
      wdata_q <= req_wdata;
      err_q   <= fault;
    end
  end

  // Gating with rst_n keeps a reset on the RESP edge from committing the write.
  assign ram_en = rst_n && (state == ST_RESP);
  assign ram_we = (we_q && !err_q) ? lane_mask(size_q, lane_q) : 4'b0000;

  always_comb begin
    case (size_q)
      SZ_B:    ram_wdata = {4{wdata_q[7:0]}};
      SZ_H:    ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign shifted = ram_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && err_q;
  assign rsp_rdata = (rsp_valid_q && !err_q && !we_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_data_ram_lsu.sv
// Bench for data_ram_lsu: two instances (0 and 3 wait states) checked against
// directed vectors, a byte-array reference model, and reset-cancel sequences.
module tb_data_ram_lsu;

  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int NB    = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n        [2];
  logic          req_valid    [2];
  logic          req_ready    [2];
  logic          req_we       [2];
  logic [1:0]    req_size     [2];
  logic          req_unsigned [2];
  logic [AW-1:0] req_addr     [2];
  logic [31:0]   req_wdata    [2];
  logic          rsp_valid    [2];
  logic [31:0]   rsp_rdata    [2];
  logic          rsp_err      [2];

  int compared   = 0;
  int mismatched = 0;
  int ws [2] = '{0, 3};
  logic [7:0] mem_model [2][NB];

  data_ram_lsu #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_ram_lsu #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: byte array, size/alignment/range rules applied arithmetically.
  function automatic void model(input int idx, input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] base, v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rdata = 32'd0;
    err = (size == 2'd3) || (addr >= 32'(NB));
    if (MIS && size != 2'd3 && (addr % n) != 0) err = 1'b1;
    if (err) return;
    base = addr - (addr % n);
    if (we) begin
      for (int k = 0; k < n; k++) mem_model[idx][base + k] = 8'(wdata >> (8 * k));
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(mem_model[idx][base + k]) << (8 * k));
      if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rdata = v;
    end
  endfunction

  task automatic txn(input int idx, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid[idx] = 1'b1; req_we[idx] = we; req_size[idx] = size;
    req_unsigned[idx] = uns; req_addr[idx] = addr; req_wdata[idx] = wdata;
    check("idle_ready", 32'(req_ready[idx]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    lat = -1; rdata = 32'd0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid[idx]) begin
        lat = n; rdata = rsp_rdata[idx]; err = rsp_err[idx];
        break;
      end
      check("busy_ready", 32'(req_ready[idx]), 32'd0);
      check("quiet_rdata", rsp_rdata[idx], 32'd0);
      check("quiet_err", 32'(rsp_err[idx]), 32'd0);
      @(negedge clk);
    end
    $display("txn dut%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             idx, we, size, uns, addr, wdata, rdata, err, lat);
  endtask

  // Store that is cancelled by reset asserted during cycle rst_cycle after accept.
  task automatic cancel_store(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                              input int rst_cycle);
    int seen = 0;
    @(negedge clk);
    req_valid[idx] = 1'b1; req_we[idx] = 1'b1; req_size[idx] = 2'd2;
    req_unsigned[idx] = 1'b0; req_addr[idx] = addr; req_wdata[idx] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    for (int n = 1; n < rst_cycle; n++) @(negedge clk);
    rst_n[idx] = 1'b0;
    @(negedge clk);
    rst_n[idx] = 1'b1;
    check("cancel_ready", 32'(req_ready[idx]), 32'd1);
    check("cancel_valid0", 32'(rsp_valid[idx]), 32'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid[idx]) seen++;
    end
    check("cancel_no_rsp", 32'(seen), 32'd0);
    $display("txn dut%0d cancelled store addr=%h wdata=%h rst_cycle=%0d rsp_seen=%0d",
             idx, addr, wdata, rst_cycle, seen);
  endtask

  function automatic void add(input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd, er_d, v;
    logic er, er_e;
    int lat, idx, sel;
    bit we, uns;
    logic [1:0] size;
    logic [31:0] addr, wdata;

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
      req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(req_ready[i]), 32'd1);
      check("reset_valid", 32'(rsp_valid[i]), 32'd0);
      check("reset_rdata", rsp_rdata[i], 32'd0);
      check("reset_err", 32'(rsp_err[i]), 32'd0);
    end

    // Give every word a known value so random loads are predictable.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < DEPTH; w++) begin
        v = $urandom;
        model(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), v, er_d, er_e);
        txn(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), v, rd, er, lat);
        check("fill_err", 32'(er), 32'd0);
        check("fill_lat", 32'(lat), 32'(2 + ws[i]));
      end
    end

    add(1, 2'd2, 0, 32'h10, 32'h8765_4321, 32'h0, 0);
    add(0, 2'd2, 0, 32'h10, 32'h0,         32'h8765_4321, 0);
    add(0, 2'd0, 0, 32'h13, 32'h0,         32'hFFFF_FF87, 0);
    add(0, 2'd0, 1, 32'h13, 32'h0,         32'h0000_0087, 0);
    add(0, 2'd1, 0, 32'h10, 32'h0,         32'h0000_4321, 0);
    add(0, 2'd1, 1, 32'h12, 32'h0,         32'h0000_8765, 0);
    add(1, 2'd0, 0, 32'h11, 32'h0000_00AA, 32'h0, 0);
    add(0, 2'd2, 1, 32'h10, 32'h0,         32'h8765_AA21, 0);
    add(1, 2'd0, 0, 32'h12, 32'hFFFF_FF55, 32'h0, 0);
    add(0, 2'd2, 0, 32'h10, 32'h0,         32'h8755_AA21, 0);
    add(1, 2'd2, 0, 32'h20, 32'h1122_3344, 32'h0, 0);
    add(1, 2'd2, 0, 32'h22, 32'hDEAD_BEEF, 32'h0, MIS);
    add(0, 2'd2, 0, 32'h20, 32'h0,         MIS ? 32'h1122_3344 : 32'hDEAD_BEEF, 0);
    add(0, 2'd2, 0, 32'(NB), 32'h0,        32'h0, 1);
    add(1, 2'd0, 0, 32'(NB + 1), 32'h0000_0077, 32'h0, 1);
    add(0, 2'd3, 0, 32'h10, 32'h0,         32'h0, 1);
    add(1, 2'd3, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
    add(0, 2'd1, 0, 32'h11, 32'h0,         MIS ? 32'h0 : 32'hFFFF_AA21, MIS);
    add(0, 2'd2, 0, 32'h13, 32'h0,         MIS ? 32'h0 : 32'h8755_AA21, MIS);
    add(0, 2'd2, 0, 32'h10, 32'h0,         32'h8755_AA21, 0);

    for (int t = 0; t < tbl.size(); t++) begin
      model(0, tbl[t].we, tbl[t].size, tbl[t].uns, tbl[t].addr, tbl[t].wdata, er_d, er_e);
      txn(0, tbl[t].we, tbl[t].size, tbl[t].uns, tbl[t].addr, tbl[t].wdata, rd, er, lat);
      check($sformatf("tbl%0d_rdata", t), rd, tbl[t].exp_rdata);
      check($sformatf("tbl%0d_err", t), 32'(er), 32'(tbl[t].exp_err));
      check($sformatf("tbl%0d_lat", t), 32'(lat), 32'd2);
    end

    repeat (400) begin
      idx = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8) addr = 32'($urandom_range(0, NB - 1));
      else if (sel == 8) addr = 32'($urandom_range(NB - 4, NB + 7));
      else addr = $urandom;
      wdata = $urandom;
      model(idx, we, size, uns, addr, wdata, er_d, er_e);
      txn(idx, we, size, uns, addr, wdata, rd, er, lat);
      check("rand_rdata", rd, er_d);
      check("rand_err", 32'(er), 32'(er_e));
      check("rand_lat", 32'(lat), 32'(2 + ws[idx]));
    end

    // Reset on the second WAIT cycle (3 wait states) cancels the store.
    txn(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, rd, er, lat);
    model(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, er_d, er_e);
    cancel_store(1, 32'h40, 32'h0BAD_BEEF, 2);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("wait_cancel_rdata", rd, 32'hCAFE_F00D);
    check("wait_cancel_lat", 32'(lat), 32'd5);

    // Reset on the RESP edge (no wait states) must not commit the write.
    txn(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h1357_9BDF, rd, er, lat);
    model(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h1357_9BDF, er_d, er_e);
    cancel_store(0, 32'h30, 32'h2468_ACE0, 1);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
    check("resp_cancel_rdata", rd, 32'h1357_9BDF);
    check("resp_cancel_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
